key_debounce: RTL and testbench

Conditions a raw mechanical key or switch input into a clean, single-clock-domain level, and emits one-cycle rising and falling enables. It sits directly upstream of the edge-to-enable stage, or replaces it for noisy inputs. Downstream logic consumes `out`, `rising` and `falling` as ordinary clock enables. Sampling is paced by an external tick enable, so debounce time is set in ticks, not clocks.

---
 rtl/key_debounce_pkg.sv | 9 +
 rtl/key_debounce_sync_chain.sv | 28 ++
 rtl/key_debounce.sv | 146 ++++++++++++++
 tb/tb_key_debounce.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared state encoding and parameter limits for the key debouncer
package key_debounce_pkg;

    typedef enum logic [1:0] {LO, WAIT_HI, HI, WAIT_LO} db_state_t;

    localparam int SYNC_STG_MAX = 4;
    localparam int CNT_MAX      = 65535;

endpackage

// File: rtl/key_debounce_sync_chain.sv
// sync_chain: generic multi-flop synchronizer with asynchronous active-high reset
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // shift the raw input one stage toward the output every clock
    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d;
    end

    // synchronizer stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// key_debounce: tick-paced key debouncer with level, rising/falling pulses; KEY_DEBOUNCE_LONG_PRESS_EN adds long_press
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int SYNC_STG   = 2,
    parameter int STABLE_CNT = 20,
    parameter int LONG_CNT   = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in,
    output logic out,
    output logic rising,
    output logic falling,
    output logic long_press
);

    // out-of-range parameters are clamped into the legal range
    localparam int SYNC_N   = SYNC_STG < 1 ? 1 : (SYNC_STG > SYNC_STG_MAX ? SYNC_STG_MAX : SYNC_STG);
    localparam int STABLE_N = STABLE_CNT < 1 ? 1 : (STABLE_CNT > CNT_MAX ? CNT_MAX : STABLE_CNT);
    localparam int CW       = $clog2(STABLE_N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_N - 1);

    logic          s;
    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          out_q, out_d;
    logic          rising_q, rising_d;
    logic          falling_q, falling_d;

    sync_chain #(.STAGES(SYNC_N)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (s)
    );

    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;

    // debounce FSM: a bounce always beats a coincident tick; out and pulses follow the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = LO;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = HI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = LO;
                cnt_d   = '0;
            end
        endcase
        out_d     = state_d == HI || state_d == WAIT_LO;
        rising_d  = out_d && !out_q;
        falling_d = !out_d && out_q;
    end

    // FSM, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LO;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            rising_q  <= 1'b0;
            falling_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            rising_q  <= rising_d;
            falling_q <= falling_d;
        end
    end

    assign out     = out_q;
    assign rising  = rising_q;
    assign falling = falling_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int LONG_N = LONG_CNT < 1 ? 1 : (LONG_CNT > CNT_MAX ? CNT_MAX : LONG_CNT);
    localparam int LW     = $clog2(LONG_N + 1);
    localparam logic [LW-1:0] LONG_TOP  = LW'(LONG_N);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_N - 1);

    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          long_press_q, long_press_d;

    // hold-time counter parks at LONG_N so the pulse fires once per press
    always_comb begin
        long_cnt_d   = !out_q ? '0 : (tick && long_cnt_q != LONG_TOP) ? long_cnt_q + 1'b1 : long_cnt_q;
        long_press_d = out_q && tick && long_cnt_q == LONG_LAST;
    end

    // long-press counter and pulse register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_cnt_q   <= '0;
            long_press_q <= 1'b0;
        end else begin
            long_cnt_q   <= long_cnt_d;
            long_press_q <= long_press_d;
        end
    end

    assign long_press = long_press_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed checks of debounce latency, bounce rejection, collisions and reset
module tb_key_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic in = 1'b0;
    logic out, rising, falling, long_press;

    int  n_chk = 0, n_fail = 0;
    int  n_rise = 0, n_fall = 0, n_long = 0, bad = 0, ph = 0;
    bit  tick_auto = 1'b1, out_prev = 1'b0;
    time rise_t = 0, fall_t = 0, long_t = 0, t0 = 0;

    key_debounce #(.SYNC_STG(2), .STABLE_CNT(4), .LONG_CNT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .in         (in),
        .out        (out),
        .rising     (rising),
        .falling    (falling),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    // pulse bookkeeping; rising/falling must coincide exactly with out changing
    always @(negedge clk) begin
        if (rising) begin
            n_rise++;
            rise_t = $time;
        end
        if (falling) begin
            n_fall++;
            fall_t = $time;
        end
        if (long_press) begin
            n_long++;
            long_t = $time;
        end
        if (!rst && rising !== (out && !out_prev)) bad++;
        if (!rst && falling !== (!out && out_prev)) bad++;
        out_prev = out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step1(input bit force_t);
        @(negedge clk);
        ph = (ph == 9) ? 0 : ph + 1;
        tick = force_t || (tick_auto && ph == 0);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) step1(1'b0);
    endtask

    task automatic align();
        repeat (10) if (ph != 0) step1(1'b0);
    endtask

    task automatic clr();
        n_rise = 0;
        n_fall = 0;
        n_long = 0;
    endtask

    function automatic int lat(input time t);
        return int'((t - t0 + 1) / 10);
    endfunction

    initial begin
        step(3);
        check("rst_out", out, 0);
        check("rst_rising", rising, 0);
        check("rst_falling", falling, 0);
        check("rst_long", long_press, 0);
        rst = 1'b0;
        step(20);
        check("idle_out", out, 0);

        clr();
        align();
        in = 1'b1;
        t0 = $time;
        step(100);
        check("press_out", out, 1);
        check("press_rise_cnt", n_rise, 1);
        check("press_latency", lat(rise_t), 41);
        check("press_no_fall", n_fall, 0);
        check("press_pulse_shape", bad, 0);

        step(100);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        check("long_cnt", n_long, 1);
        check("long_delay", int'(long_t - rise_t), 800);
`else
        check("long_tied_off", n_long, 0);
`endif

        clr();
        align();
        in = 1'b0;
        t0 = $time;
        step(100);
        check("release_out", out, 0);
        check("release_fall_cnt", n_fall, 1);
        check("release_latency", lat(fall_t), 41);
        check("release_no_rise", n_rise, 0);
        check("release_no_long", n_long, 0);

        clr();
        align();
        in = 1'b1;
        step(30);
        in = 1'b0;
        step(70);
        check("glitch_no_rise", n_rise, 0);
        check("glitch_out", out, 0);

        clr();
        align();
        for (int i = 0; i < 8; i++) begin
            in = (i % 2 == 0);
            step(7);
        end
        check("bounce_no_rise", n_rise, 0);
        check("bounce_out", out, 0);
        in = 1'b1;
        t0 = $time;
        step(100);
        check("settle_rise_cnt", n_rise, 1);
        check("settle_latency", lat(rise_t), 35);
        check("settle_out", out, 1);

        clr();
        #2 rst = 1'b1;
        #1 check("async_rst_out", out, 0);
        step(3);
        check("async_rst_rising", rising, 0);
        check("async_rst_no_fall", n_fall, 0);
        align();
        rst = 1'b0;
        t0 = $time;
        step(60);
        check("rerun_rise_cnt", n_rise, 1);
        check("rerun_latency", lat(rise_t), 41);
        check("rerun_out", out, 1);

        clr();
        in = 1'b0;
        step(60);
        check("drop_out", out, 0);
        check("drop_fall_cnt", n_fall, 1);

        tick_auto = 1'b0;
        step(3);
        clr();
        in = 1'b1;
        step(2);
        repeat (3) step1(1'b1);
        in = 1'b0;
        step(1);
        step1(1'b1);
        step(5);
        check("collide_no_rise", n_rise, 0);
        check("collide_out", out, 0);
        in = 1'b1;
        step(2);
        repeat (3) step1(1'b1);
        step(3);
        check("fresh3_no_rise", n_rise, 0);
        step1(1'b1);
        step(2);
        check("fresh4_rise", n_rise, 1);
        check("fresh4_out", out, 1);

        in = 1'b0;
        tick_auto = 1'b1;
        step(60);
        check("pre_mid_out", out, 0);
        tick_auto = 1'b0;
        step(3);
        clr();
        in = 1'b1;
        step(2);
        step1(1'b1);
        step1(1'b1);
        step(1);
        #2 rst = 1'b1;
        #1 check("mid_rst_out", out, 0);
        check("mid_rst_rising", rising, 0);
        check("mid_rst_falling", falling, 0);
        check("mid_rst_long", long_press, 0);
        repeat (3) step1(1'b1);
        check("mid_rst_no_rise", n_rise, 0);
        tick_auto = 1'b1;
        align();
        rst = 1'b0;
        t0 = $time;
        step(60);
        check("mid_rerun_rise_cnt", n_rise, 1);
        check("mid_rerun_latency", lat(rise_t), 41);

        check("pulse_shape", bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
